// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the cache-to-memory arbiter.
// Round-robin arbitration is enabled by defining MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  localparam int ARB_AW        = 26;
  localparam int ARB_DW        = 32;
  localparam int ARB_BURST_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_RBURST,
    ST_WBURST
  } state_e;

  typedef enum logic [1:0] {
    OWN_IC,
    OWN_DR,
    OWN_DW
  } owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner selection among I-cache read, D-cache read and writeback.
// MEM_ARB_ROUND_ROBIN_EN: rotating priority, else fixed dw > dr > ic.
module mem_arb_grant
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_take,
`endif
  input  logic   i_ic_valid,
  input  logic   i_dr_valid,
  input  logic   i_dw_valid,
  output logic   o_any,
  output owner_e o_owner
);

  assign o_any = i_ic_valid | i_dr_valid | i_dw_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= OWN_IC;
    end else if (i_take) begin
      r_last <= o_owner;
    end
  end

  // Cycle dw -> dr -> ic -> dw, starting after the last winner
  always_comb begin
    o_owner = OWN_IC;
    unique case (r_last)
      OWN_DW:
        o_owner = i_dr_valid ? OWN_DR :
                  i_ic_valid ? OWN_IC : OWN_DW;
      OWN_DR:
        o_owner = i_ic_valid ? OWN_IC :
                  i_dw_valid ? OWN_DW : OWN_DR;
      default:
        o_owner = i_dw_valid ? OWN_DW :
                  i_dr_valid ? OWN_DR : OWN_IC;
    endcase
  end
`else
  always_comb begin
    if (i_dw_valid) begin
      o_owner = OWN_DW;
    end else if (i_dr_valid) begin
      o_owner = OWN_DR;
    end else begin
      o_owner = OWN_IC;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding line-burst arbiter between caches and memory.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = ARB_AW,
  parameter int DW        = ARB_DW,
  parameter int BURST_LEN = ARB_BURST_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_req_valid,
  input  logic [AW-1:0]         ic_req_addr,
  output logic                  ic_req_ready,
  output logic                  ic_resp_valid,
  input  logic                  dr_req_valid,
  input  logic [AW-1:0]         dr_req_addr,
  output logic                  dr_req_ready,
  output logic                  dr_resp_valid,
  output logic [DW-1:0]         rd_data,
  input  logic                  dw_req_valid,
  input  logic [AW-1:0]         dw_req_addr,
  input  logic [BURST_LEN*DW-1:0] dw_req_line,
  output logic                  dw_req_ready,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_write,
  output logic [AW-1:0]         mem_cmd_addr,
  output logic [DW-1:0]         mem_wdata,
  output logic                  mem_wdata_valid,
  input  logic                  mem_wdata_ready,
  input  logic [DW-1:0]         mem_rdata,
  input  logic                  mem_rdata_valid
);

  localparam int BW  = $clog2(BURST_LEN);
  localparam int OFS = $clog2(BURST_LEN * DW / 8);
  localparam logic [BW-1:0] LAST  = BW'(BURST_LEN - 1);
  localparam logic [AW-1:0] ALIGN = ~AW'((1 << OFS) - 1);

  state_e                        r_state;
  owner_e                        r_owner;
  logic [AW-1:0]                 r_addr;
  logic [BW-1:0]                 r_beat;
  logic                          r_cmd_valid;
  logic                          r_cmd_write;
  logic                          r_wvalid;
  logic [DW-1:0]                 r_rdata;
  logic                          r_ic_rv;
  logic                          r_dr_rv;
  logic [BURST_LEN-1:0][DW-1:0]  r_line;

  logic                          w_any;
  owner_e                        w_owner;
  logic                          w_take;
  logic [AW-1:0]                 w_addr;

  mem_arb_grant u_grant (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk        (clk),
    .rst_n      (rst_n),
    .i_take     (w_take),
`endif
    .i_ic_valid (ic_req_valid),
    .i_dr_valid (dr_req_valid),
    .i_dw_valid (dw_req_valid),
    .o_any      (w_any),
    .o_owner    (w_owner)
  );

  // Ready is gated by rst_n so every output is 0 while reset is held
  assign w_take       = rst_n & (r_state == ST_IDLE) & w_any;
  assign ic_req_ready = w_take & (w_owner == OWN_IC);
  assign dr_req_ready = w_take & (w_owner == OWN_DR);
  assign dw_req_ready = w_take & (w_owner == OWN_DW);

  always_comb begin
    w_addr = ic_req_addr;
    unique case (w_owner)
      OWN_DR:  w_addr = dr_req_addr;
      OWN_DW:  w_addr = dw_req_addr;
      default: w_addr = ic_req_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IC;
      r_addr      <= '0;
      r_beat      <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_write <= 1'b0;
      r_wvalid    <= 1'b0;
      r_rdata     <= '0;
      r_ic_rv     <= 1'b0;
      r_dr_rv     <= 1'b0;
    end else begin
      r_ic_rv <= 1'b0;
      r_dr_rv <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner     <= w_owner;
            r_addr      <= w_addr & ALIGN;
            r_cmd_valid <= 1'b1;
            r_cmd_write <= (w_owner == OWN_DW);
            r_state     <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (mem_cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_beat      <= '0;
            if (r_cmd_write) begin
              r_wvalid <= 1'b1;
              r_state  <= ST_WBURST;
            end else begin
              r_state  <= ST_RBURST;
            end
          end
        end
        ST_RBURST: begin
          if (mem_rdata_valid) begin
            r_rdata <= mem_rdata;
            r_ic_rv <= (r_owner == OWN_IC);
            r_dr_rv <= (r_owner == OWN_DR);
            r_beat  <= r_beat + 1'b1;
            if (r_beat == LAST) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_WBURST: begin
          if (mem_wdata_ready) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == LAST) begin
              r_wvalid <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Line buffer holds data only; its contents are don't-care out of WBURST
  always_ff @(posedge clk) begin
    if (dw_req_ready) begin
      r_line <= dw_req_line;
    end
  end

  assign mem_cmd_valid   = r_cmd_valid;
  assign mem_cmd_write   = r_cmd_write;
  assign mem_cmd_addr    = r_addr;
  assign mem_wdata_valid = r_wvalid;
  assign mem_wdata       = r_wvalid ? r_line[r_beat] : '0;
  assign rd_data         = r_rdata;
  assign ic_resp_valid   = r_ic_rv;
  assign dr_resp_valid   = r_dr_rv;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: grant tables, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam logic [AW-1:0] AMASK = 26'h3FFFFF0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_v [3];
  logic [AW-1:0] req_a [3];
  logic [BL*DW-1:0] dw_line;

  logic ic_req_ready, ic_resp_valid;
  logic dr_req_ready, dr_resp_valid;
  logic dw_req_ready;
  logic [DW-1:0] rd_data;
  logic mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
  logic [AW-1:0] mem_cmd_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic mem_wdata_valid, mem_wdata_ready, mem_rdata_valid;

  mem_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ic_req_valid    (req_v[0]),
    .ic_req_addr     (req_a[0]),
    .ic_req_ready    (ic_req_ready),
    .ic_resp_valid   (ic_resp_valid),
    .dr_req_valid    (req_v[1]),
    .dr_req_addr     (req_a[1]),
    .dr_req_ready    (dr_req_ready),
    .dr_resp_valid   (dr_resp_valid),
    .rd_data         (rd_data),
    .dw_req_valid    (req_v[2]),
    .dw_req_addr     (req_a[2]),
    .dw_req_line     (dw_line),
    .dw_req_ready    (dw_req_ready),
    .mem_cmd_valid   (mem_cmd_valid),
    .mem_cmd_ready   (mem_cmd_ready),
    .mem_cmd_write   (mem_cmd_write),
    .mem_cmd_addr    (mem_cmd_addr),
    .mem_wdata       (mem_wdata),
    .mem_wdata_valid (mem_wdata_valid),
    .mem_wdata_ready (mem_wdata_ready),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: ports 0=ic 1=dr 2=dw
  bit busy, cmd_done, resp_exp;
  int cur_own, beats, resp_own, last_g, stall;
  logic [AW-1:0] cur_addr;
  logic [BL*DW-1:0] cur_line;
  logic [DW-1:0] resp_data;
  int pct = 100;
  int wr_stall = 0;
  bit hold = 0;
  bit fire [3];
  int last_fire = -1;
  int grants [$];
  logic [DW-1:0] ic_seen [$];
  logic [DW-1:0] wr_seen [$];
  int dr_pulses = 0;
  int wv_cycles = 0;
  int n_done = 0;
  logic [AW-1:0] cmd_seen;

  typedef struct {
    logic [2:0]    v;
    logic [AW-1:0] a;
    int            exp_own;
    logic [AW-1:0] exp_addr;
  } vec_t;
  vec_t tbl [8];

  function automatic void chk(string nm, logic [127:0] act,
                              logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void timeout(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL timeout %s: got no progress, required completion", nm);
  endfunction

  function automatic logic [127:0] outs();
    return 128'({ic_req_ready, ic_resp_valid, dr_req_ready, dr_resp_valid,
                 rd_data, dw_req_ready, mem_cmd_valid, mem_cmd_write,
                 mem_cmd_addr, mem_wdata, mem_wdata_valid});
  endfunction

  function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a, int b);
    if (a == 26'h0001230) return 32'hA0 + 32'(b);
    return {6'h0, a} ^ (32'h9E3779B9 * 32'(b + 1));
  endfunction

  function automatic int pick(logic [2:0] v, int last);
    int p;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      p = (last - k + 3) % 3;
      if (v[p]) return p;
    end
`else
    for (int k = 0; k < 3; k++) begin
      p = 2 - k + (last - last);
      if (v[p]) return p;
    end
`endif
    return -1;
  endfunction

  // Memory responder and checker; inputs chosen here apply at the next edge
  always @(negedge clk) begin : mon
    logic ncr, nwr, nrv;
    logic [DW-1:0] nrd;
    logic [2:0] rdy, vv;
    int w, act;
    bit b0;
    ncr = ($urandom_range(99) < pct);
    nwr = ($urandom_range(99) < pct);
    nrv = ($urandom_range(99) < pct);
    nrd = $urandom;
    if (!rst_n) begin
      chk("reset_outs", outs(), '0);
      busy = 0;
      resp_exp = 0;
      last_g = 0;
      stall = 0;
      for (int p = 0; p < 3; p++) fire[p] = 0;
    end else begin
      if (ic_resp_valid) ic_seen.push_back(rd_data);
      if (dr_resp_valid) dr_pulses++;
      if (mem_wdata_valid) wv_cycles++;
      chk("ic_resp_valid", ic_resp_valid, resp_exp && resp_own == 0);
      chk("dr_resp_valid", dr_resp_valid, resp_exp && resp_own == 1);
      if (resp_exp) chk("rd_data", rd_data, resp_data);
      resp_exp = 0;
      b0 = busy;
      chk("cmd_valid", mem_cmd_valid, busy && !cmd_done);
      chk("wdata_valid", mem_wdata_valid, busy && cmd_done && cur_own == 2);
      if (busy && !cmd_done) begin
        chk("cmd_addr", mem_cmd_addr, cur_addr);
        chk("cmd_write", mem_cmd_write, cur_own == 2);
        if (ncr) begin
          cmd_done = 1;
          beats = 0;
          stall = wr_stall;
          cmd_seen = mem_cmd_addr;
        end
      end else if (busy && cur_own == 2) begin
        if (stall > 0) begin
          nwr = 0;
          stall--;
        end
        chk("wdata", mem_wdata, cur_line[beats*DW +: DW]);
        if (nwr) begin
          wr_seen.push_back(mem_wdata);
          beats++;
          if (beats == BL) begin
            busy = 0;
            n_done++;
          end
        end
      end else if (busy) begin
        if (nrv) begin
          nrd = mem_word(cur_addr, beats);
          resp_exp = 1;
          resp_own = cur_own;
          resp_data = nrd;
          beats++;
          if (beats == BL) begin
            busy = 0;
            n_done++;
          end
        end
      end
      vv = {req_v[2], req_v[1], req_v[0]};
      rdy = {dw_req_ready, dr_req_ready, ic_req_ready};
      w = b0 ? -1 : pick(vv, last_g);
      chk("req_ready", rdy, (w < 0) ? 3'b000 : 3'(1 << w));
      act = rdy[2] ? 2 : rdy[1] ? 1 : rdy[0] ? 0 : -1;
      if (act >= 0) begin
        grants.push_back(act);
        fire[act] = 1;
        last_fire = act;
      end
      if (w >= 0) begin
        busy = 1;
        cmd_done = 0;
        beats = 0;
        cur_own = w;
        cur_addr = req_a[w] & AMASK;
        cur_line = dw_line;
        last_g = w;
      end
    end
    mem_cmd_ready = ncr;
    mem_wdata_ready = nwr;
    mem_rdata_valid = nrv;
    mem_rdata = nrd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) begin
      if (fire[p]) begin
        fire[p] = 0;
        if (!hold) req_v[p] = 0;
      end
    end
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((busy || req_v[0] || req_v[1] || req_v[2]) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) timeout("idle");
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst_n = 0;
    for (int p = 0; p < 3; p++) req_v[p] = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  int ord3 [3] = '{2, 1, 0};
`ifdef MEM_ARB_ROUND_ROBIN_EN
  int ord6 [6] = '{2, 1, 0, 2, 1, 0};
`else
  int ord6 [6] = '{2, 2, 2, 2, 2, 2};
`endif
  logic [DW-1:0] wexp [4] = '{32'hDDCCBBAA, 32'hCCBBAA99,
                              32'h88776655, 32'h44332211};

  initial begin
    int n;
    tbl[0] = '{3'b001, 26'h0001234, 0, 26'h0001230};
    tbl[1] = '{3'b010, 26'h00ABCDF, 1, 26'h00ABCD0};
    tbl[2] = '{3'b100, 26'h1000008, 2, 26'h1000000};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tbl[3] = '{3'b111, 26'h0000000, 1, 26'h0000000};
    tbl[4] = '{3'b011, 26'h2FEDCBA, 0, 26'h2FEDCB0};
    tbl[5] = '{3'b101, 26'h000000F, 2, 26'h0000000};
    tbl[6] = '{3'b110, 26'h155555A, 1, 26'h1555550};
    tbl[7] = '{3'b111, 26'h3FFFFFF, 0, 26'h3FFFFF0};
`else
    tbl[3] = '{3'b111, 26'h0000000, 2, 26'h0000000};
    tbl[4] = '{3'b011, 26'h2FEDCBA, 1, 26'h2FEDCB0};
    tbl[5] = '{3'b101, 26'h000000F, 2, 26'h0000000};
    tbl[6] = '{3'b110, 26'h155555A, 2, 26'h1555550};
    tbl[7] = '{3'b111, 26'h3FFFFFF, 2, 26'h3FFFFF0};
`endif
    for (int p = 0; p < 3; p++) begin
      req_v[p] = 0;
      req_a[p] = '0;
    end
    dw_line = '0;
    mem_cmd_ready = 0;
    mem_wdata_ready = 0;
    mem_rdata_valid = 0;
    mem_rdata = '0;
    rst_n = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();

    pct = 80;
    for (int i = 0; i < 8; i++) begin
      dw_line = {$urandom, $urandom, $urandom, $urandom};
      for (int p = 0; p < 3; p++) begin
        req_v[p] = tbl[i].v[p];
        req_a[p] = tbl[i].a;
      end
      last_fire = -1;
      n = 0;
      while (last_fire < 0 && n < 20) begin
        tick();
        n++;
      end
      if (last_fire < 0) timeout("tbl_grant");
      chk("tbl_grant", last_fire, tbl[i].exp_own);
      for (int p = 0; p < 3; p++) req_v[p] = 0;
      wait_idle(200);
      chk("tbl_cmd_addr", cmd_seen, tbl[i].exp_addr);
    end

    pct = 100;
    ic_seen.delete();
    dr_pulses = 0;
    req_a[0] = 26'h0001234;
    req_v[0] = 1;
    wait_idle(100);
    chk("lone_ic_cmd_addr", cmd_seen, 26'h0001230);
    chk("lone_ic_beats", ic_seen.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < ic_seen.size()) chk("lone_ic_data", ic_seen[k], 32'hA0 + k);
    chk("lone_ic_dr_quiet", dr_pulses, 0);

    wr_stall = 3;
    wr_seen.delete();
    wv_cycles = 0;
    dw_line = {32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'hDDCCBBAA};
    req_a[2] = 26'h0200047;
    req_v[2] = 1;
    wait_idle(100);
    wr_stall = 0;
    chk("wb_beats", wr_seen.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < wr_seen.size()) chk("wb_word", wr_seen[k], wexp[k]);
    chk("wb_valid_cycles", wv_cycles, 7);
    chk("wb_idle_after", mem_wdata_valid, 0);

    do_reset();
    grants.delete();
    for (int p = 0; p < 3; p++) begin
      req_v[p] = 1;
      req_a[p] = 26'(32'h0040000 * (p + 1) + 5);
    end
    wait_idle(300);
    chk("all3_count", grants.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < grants.size()) chk("all3_order", grants[k], ord3[k]);

    do_reset();
    grants.delete();
    hold = 1;
    for (int p = 0; p < 3; p++) req_v[p] = 1;
    n = 0;
    while (grants.size() < 6 && n < 400) begin
      tick();
      n++;
    end
    if (grants.size() < 6) timeout("hold6");
    hold = 0;
    for (int p = 0; p < 3; p++) req_v[p] = 0;
    wait_idle(100);
    chk("hold6_count", grants.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < grants.size()) chk("hold6_order", grants[k], ord6[k]);

    pct = 50;
    ic_seen.delete();
    req_a[0] = 26'h0123458;
    req_v[0] = 1;
    n = 0;
    while (ic_seen.size() < 2 && n < 200) begin
      tick();
      n++;
    end
    if (ic_seen.size() < 2) timeout("beat2");
    rst_n = 0;
    req_v[0] = 0;
    #1;
    chk("rst_immediate", outs(), '0);
    tick();
    tick();
    rst_n = 1;
    ic_seen.delete();
    dr_pulses = 0;
    repeat (10) tick();
    chk("no_resp_after_rst", ic_seen.size() + dr_pulses, 0);
    req_a[1] = 26'h0ABC123;
    req_v[1] = 1;
    wait_idle(200);
    chk("dr_after_rst_beats", dr_pulses, 4);
    chk("dr_after_rst_addr", cmd_seen, 26'h0ABC120);

    pct = 70;
    n_done = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 3; p++) begin
        if (!req_v[p] && $urandom_range(7) == 0) begin
          req_a[p] = 26'($urandom);
          if (p == 2) dw_line = {$urandom, $urandom, $urandom, $urandom};
          req_v[p] = 1;
        end
      end
      tick();
    end
    wait_idle(500);
    chk("random_progress", n_done > 50, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter
Interface
REQ-001 AW, 26, byte address width.
REQ-002 DW, 32, data word width.
REQ-003 BURST_LEN, 4, words per cache-line transfer; power of 2, >=2.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 ic_req_valid  in  1  I-cache line-read request.
REQ-007 ic_req_addr  in  AW  I-cache line address.
REQ-008 ic_req_ready  out  1  I-cache request accepted this cycle.
REQ-009 ic_resp_valid  out  1  rd_data holds an I-cache beat.
REQ-010 dr_req_valid  in  1  D-cache line-read request.
REQ-011 dr_req_addr  in  AW  D-cache read line address.
REQ-012 dr_req_ready  out  1  D-cache read accepted this cycle.
REQ-013 dr_resp_valid  out  1  rd_data holds a D-cache beat.
REQ-014 rd_data  out  DW  registered read beat, shared by both read ports.
REQ-015 dw_req_valid  in  1  D-cache line-writeback request.
REQ-016 dw_req_addr  in  AW  writeback line address.
REQ-017 dw_req_line  in  BURST_LEN*DW  writeback line; word 0 in bits DW-1:0.
REQ-018 dw_req_ready  out  1  writeback accepted; line captured this cycle.
REQ-019 mem_cmd_valid  out  1  command to memory valid.
REQ-020 mem_cmd_ready  in  1  memory accepts command.
REQ-021 mem_cmd_write  out  1  1 = write burst, 0 = read burst.
REQ-022 mem_cmd_addr  out  AW  line-aligned command address.
REQ-023 mem_wdata  out  DW  write beat.
REQ-024 mem_wdata_valid  out  1  write beat valid.
REQ-025 mem_wdata_ready  in  1  memory consumes write beat.
REQ-026 mem_rdata  in  DW  read beat from memory.
REQ-027 mem_rdata_valid  in  1  read beat valid.
Function
REQ-028 FSM states IDLE, CMD, RBURST, WBURST; exactly one transaction outstanding at any time.
REQ-029 IDLE with any request valid: grant one; assert that port's req_ready for exactly one cycle; latch address with low log2(BURST_LEN*DW/8) bits forced to 0, record owner, capture dw_req_line into line buffer on write grant; go to CMD.
REQ-030 All req_ready outputs are 0 outside IDLE; requesters hold valid and address until ready; simultaneous requests resolved by the grant policy (REQ-039).
REQ-031 CMD: mem_cmd_valid=1; mem_cmd_addr and mem_cmd_write held stable until mem_cmd_ready; then go to RBURST or WBURST with beat_cnt=0.
REQ-032 RBURST: on each mem_rdata_valid, rd_data<=mem_rdata and owner's resp_valid pulses for one cycle (1-cycle latency); beats delivered in order 0..BURST_LEN-1.
REQ-033 WBURST: mem_wdata_valid=1, mem_wdata=line buffer word beat_cnt; beat advances on mem_wdata_ready.
REQ-034 beat_cnt is log2(BURST_LEN) bits and wraps to 0 on the last beat; the last beat returns the FSM to IDLE; next grant is no earlier than the following cycle.
REQ-035 mem_rdata_valid outside RBURST, mem_cmd_ready outside CMD, and mem_wdata_ready outside WBURST are ignored.
Reset
REQ-036 Reset forces state IDLE, beat_cnt 0, all outputs 0; the line buffer is not reset.
REQ-037 Reset mid-transaction abandons it; no resp_valid is issued for it after rst_n deasserts.
Configuration
REQ-038 MEM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration; the most recently granted port has lowest priority; the last-grant register resets to ic, giving order dw>dr>ic after reset.
REQ-039 MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority dw > dr > ic; no last-grant register.
Structure
REQ-040 Package mem_arb_pkg: state enum, owner enum (OWN_IC, OWN_DR, OWN_DW), default BURST_LEN and widths.
REQ-041 Sub-module mem_arb_grant: picks the winner from three valids; holds the last-grant register when round-robin is compiled in.
Verification
REQ-042 Lone ic read at 0x0001234, memory returns 0xA0..0xA3 -> mem_cmd_addr 0x0001230, ic_resp_valid 4 pulses carrying 0xA0..0xA3, dr_resp_valid stays 0.
REQ-043 dw, dr, ic all valid in the same cycle, fixed priority -> grant order dw, dr, ic.
REQ-044 Same stimulus with MEM_ARB_ROUND_ROBIN_EN, all held valid for 6 grants -> grant order dw, dr, ic, dw, dr, ic.
REQ-045 Writeback of line 0x44332211_..._DDCCBBAA with mem_wdata_ready low 3 cycles -> beats emitted word 0 first, each held stable until ready, then IDLE.
REQ-046 rst_n asserted after read beat 2 -> outputs 0 immediately; no resp_valid follows; next request is served normally.
